// File: rtl/pid_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : pid_sched_if
//  Brief    : Register bus between a host and the PID scheduler. Each
//             channel has four registers, addressed as {channel, reg}.
//  Revision : 1.0  initial release
// ============================================================================
interface pid_sched_if #(
    parameter int aw = 1
);
    logic            bus_we;
    logic [aw+1:0]   bus_addr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;

    modport master (output bus_we, output bus_addr, output bus_wdata, input bus_rdata);
    modport slave  (input bus_we, input bus_addr, input bus_wdata, output bus_rdata);
endinterface
`default_nettype wire

// File: rtl/pid_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pid_sched
//  Brief    : Per-channel setpoint, gain and output register file that sits
//             around a time-shared PID datapath. It computes a saturated
//             error for the channel being served and captures the datapath
//             result on each rising edge of ce.
//  Options  : PID_SCHED_SLEW_EN - the effective setpoint moves toward the
//             target by at most 'rate' on each capture of its channel.
//  Revision : 1.0  initial release
// ============================================================================
module pid_sched #(
    parameter int aw = 1,
    parameter int ew = 24,
    parameter int ow = 12,
    parameter int cw = 6
) (
    input  wire                         clk_pid,
    input  wire                         reset_n,
    pid_sched_if.slave                  bus,
    input  wire [(2**aw)*ew-1:0]        pos,
    input  wire [aw-1:0]                a,
    input  wire                         ce,
    input  wire [ow-1:0]                m_k_out,
    output logic signed [ew-1:0]        error,
    output logic signed [cw-1:0]        KP,
    output logic signed [cw-1:0]        KI,
    output logic signed [cw-1:0]        KD,
    output logic [(2**aw)*ow-1:0]       m_out,
    output logic [(2**aw)-1:0]          upd
);
    localparam int C_AN = 2**aw;
    // Symmetric clamp: the most negative code is never produced.
    localparam logic signed [ew:0] C_EMAX = {2'b00, {(ew-1){1'b1}}};
    localparam logic signed [ew:0] C_EMIN = -C_EMAX;

    logic signed [ew-1:0] target_q [C_AN];
    logic signed [ew-1:0] target_d [C_AN];
    logic        [17:0]   gains_q  [C_AN];
    logic        [17:0]   gains_d  [C_AN];
    logic [C_AN-1:0]      en_q, en_d;
    logic signed [ew-1:0] sp_q     [C_AN];
    logic signed [ew-1:0] sp_d     [C_AN];
    logic signed [ow-1:0] mout_q   [C_AN];
    logic signed [ow-1:0] mout_d   [C_AN];
    logic [C_AN-1:0]      upd_q, upd_d;
    logic signed [ew-1:0] error_q, error_d;
    logic                 ce_q, ce_d;
    logic                 arm_q, arm_d;   // set once ce has been seen low after reset
`ifdef PID_SCHED_SLEW_EN
    logic        [15:0]   rate_q   [C_AN];
    logic        [15:0]   rate_d   [C_AN];
`endif

    logic [aw-1:0]        w_ch;
    logic [1:0]           w_reg;
    logic                 w_cap;
    logic signed [ew-1:0] w_pos    [C_AN];
    logic signed [ew-1:0] w_sp_a;
    logic signed [ew:0]   w_diff;
    logic                 w_unused_ok;

    assign w_ch        = bus.bus_addr[aw+1:2];
    assign w_reg       = bus.bus_addr[1:0];
    assign w_unused_ok = ^bus.bus_wdata;

`ifdef PID_SCHED_SLEW_EN
    // One slew step: jump to target when within rate (or rate is zero).
    function automatic logic signed [ew-1:0] slew_step(
        input logic signed [ew-1:0] tgt,
        input logic signed [ew-1:0] cur,
        input logic [15:0]          rate
    );
        logic signed [ew:0] d;
        logic signed [ew:0] mag;
        logic signed [ew:0] r;
        d   = {tgt[ew-1], tgt} - {cur[ew-1], cur};
        mag = d[ew] ? -d : d;
        r   = (ew+1)'(rate);
        if (rate == 16'd0 || mag <= r)
            slew_step = tgt;
        else if (d[ew])
            slew_step = cur - r[ew-1:0];
        else
            slew_step = cur + r[ew-1:0];
    endfunction
`endif

    // Host register writes; reg 3 is read-only.
    always_comb begin
        for (int i = 0; i < C_AN; i++) begin
            target_d[i] = target_q[i];
            gains_d[i]  = gains_q[i];
`ifdef PID_SCHED_SLEW_EN
            rate_d[i]   = rate_q[i];
`endif
        end
        en_d = en_q;
        if (bus.bus_we) begin
            case (w_reg)
                2'd0: target_d[w_ch] = bus.bus_wdata[ew-1:0];
                2'd1: gains_d[w_ch]  = bus.bus_wdata[17:0];
                2'd2: begin
                    en_d[w_ch] = bus.bus_wdata[0];
`ifdef PID_SCHED_SLEW_EN
                    rate_d[w_ch] = bus.bus_wdata[23:8];
`endif
                end
                default: ;
            endcase
        end
    end

    // Error, capture and effective-setpoint tracking for the served channel.
    always_comb begin
        for (int i = 0; i < C_AN; i++)
            w_pos[i] = pos[i*ew +: ew];
        w_cap = ce & ~ce_q & arm_q;
        ce_d  = ce;
        arm_d = arm_q | ~ce;
`ifdef PID_SCHED_SLEW_EN
        w_sp_a = sp_q[a];
`else
        w_sp_a = target_q[a];
`endif
        w_diff = {w_sp_a[ew-1], w_sp_a} - {w_pos[a][ew-1], w_pos[a]};
        if (!en_q[a])
            error_d = '0;
        else if (w_diff > C_EMAX)
            error_d = C_EMAX[ew-1:0];
        else if (w_diff < C_EMIN)
            error_d = C_EMIN[ew-1:0];
        else
            error_d = w_diff[ew-1:0];
        upd_d = '0;
        for (int i = 0; i < C_AN; i++) begin
            if (w_cap && a == aw'(i))
                upd_d[i] = 1'b1;
            if (!en_q[i])
                mout_d[i] = '0;
            else if (w_cap && a == aw'(i))
                mout_d[i] = m_k_out;
            else
                mout_d[i] = mout_q[i];
            // Disabled channels track position so enabling is bumpless.
            if (!en_q[i])
                sp_d[i] = w_pos[i];
            else begin
`ifdef PID_SCHED_SLEW_EN
                if (w_cap && a == aw'(i))
                    sp_d[i] = slew_step(target_q[i], sp_q[i], rate_q[i]);
                else
                    sp_d[i] = sp_q[i];
`else
                sp_d[i] = target_q[i];
`endif
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < C_AN; i++) begin
                target_q[i] <= '0;
                gains_q[i]  <= '0;
                sp_q[i]     <= '0;
                mout_q[i]   <= '0;
`ifdef PID_SCHED_SLEW_EN
                rate_q[i]   <= '0;
`endif
            end
            en_q    <= '0;
            upd_q   <= '0;
            error_q <= '0;
            ce_q    <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            for (int i = 0; i < C_AN; i++) begin
                target_q[i] <= target_d[i];
                gains_q[i]  <= gains_d[i];
                sp_q[i]     <= sp_d[i];
                mout_q[i]   <= mout_d[i];
`ifdef PID_SCHED_SLEW_EN
                rate_q[i]   <= rate_d[i];
`endif
            end
            en_q    <= en_d;
            upd_q   <= upd_d;
            error_q <= error_d;
            ce_q    <= ce_d;
            arm_q   <= arm_d;
        end
    end

    // Combinational register readback.
    always_comb begin
        case (w_reg)
            2'd0: bus.bus_rdata = 32'(target_q[w_ch]);
            2'd1: bus.bus_rdata = 32'(gains_q[w_ch]);
`ifdef PID_SCHED_SLEW_EN
            2'd2: bus.bus_rdata = {8'd0, rate_q[w_ch], 7'd0, en_q[w_ch]};
`else
            2'd2: bus.bus_rdata = {31'd0, en_q[w_ch]};
`endif
            default: bus.bus_rdata = 32'(mout_q[w_ch]);
        endcase
    end

    // Output packing and gain selection for the served channel.
    always_comb begin
        for (int i = 0; i < C_AN; i++)
            m_out[i*ow +: ow] = mout_q[i];
    end

    assign upd   = upd_q;
    assign error = error_q;
    assign KP    = cw'($signed(gains_q[a][5:0]));
    assign KI    = cw'($signed(gains_q[a][11:6]));
    assign KD    = cw'($signed(gains_q[a][17:12]));
endmodule
`default_nettype wire

// File: tb/tb_pid_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_sched
//  Brief    : Randomized and directed bench for pid_sched against a
//             behavioural channel model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pid_sched;
    localparam int AW = 1, EW = 24, OW = 12, CW = 6, AN = 2;
`ifdef PID_SCHED_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic             clk_pid;
    logic             reset_n;
    logic [AN*EW-1:0] pos;
    logic [AW-1:0]    a;
    logic             ce;
    logic [OW-1:0]    m_k_out;
    logic [EW-1:0]    error;
    logic [CW-1:0]    KP, KI, KD;
    logic [AN*OW-1:0] m_out;
    logic [AN-1:0]    upd;

    int n_tests = 0;
    int n_fail  = 0;

    pid_sched_if #(.aw(AW)) bus_if ();

    pid_sched #(.aw(AW), .ew(EW), .ow(OW), .cw(CW)) dut (
        .clk_pid (clk_pid),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .pos     (pos),
        .a       (a),
        .ce      (ce),
        .m_k_out (m_k_out),
        .error   (error),
        .KP      (KP),
        .KI      (KI),
        .KD      (KD),
        .m_out   (m_out),
        .upd     (upd)
    );

    initial clk_pid = 1'b0;
    always #5 clk_pid = ~clk_pid;

    // Model state
    longint m_tgt [AN];
    longint m_sp  [AN];
    longint m_mout[AN];
    longint m_err;
    int     m_gain[AN];
    int     m_rate[AN];
    bit     m_en  [AN];
    int     m_upd;
    bit     m_ceprev, m_armed;

    // Stimulus
    longint      p[AN];
    int          ai;
    bit          cei;
    longint      mk;
    bit          wei;
    int          waddr;
    logic [31:0] wdat;

    function automatic longint sx(longint v, int w);
        longint m;
        m = (longint'(1) << w) - 1;
        v = v & m;
        if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint sat(longint v);
        longint lim;
        lim = (longint'(1) << (EW - 1)) - 1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic longint step_toward(longint t, longint s, int rate);
        longint d, mag;
        d   = t - s;
        mag = (d < 0) ? -d : d;
        if (rate == 0 || mag <= rate) return t;
        return (d > 0) ? s + rate : s - rate;
    endfunction

    function automatic longint readback(int adr);
        int ch;
        ch = adr >> 2;
        case (adr & 3)
            0: return m_tgt[ch];
            1: return longint'(m_gain[ch]);
            2: return (longint'(m_rate[ch]) << 8) | longint'(m_en[ch]);
            default: return m_mout[ch];
        endcase
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < AN; i++) begin
            m_tgt[i] = 0; m_sp[i] = 0; m_mout[i] = 0;
            m_gain[i] = 0; m_rate[i] = 0; m_en[i] = 1'b0;
        end
        m_err = 0; m_upd = 0; m_ceprev = 1'b0; m_armed = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < AN; i++) pos[i*EW +: EW] = EW'(p[i]);
        a                = AW'(ai);
        ce               = cei;
        m_k_out          = OW'(mk);
        bus_if.bus_we    = wei;
        bus_if.bus_addr  = (AW+2)'(waddr);
        bus_if.bus_wdata = wdat;
    endtask

    // One clock: predict, advance, compare every output.
    task automatic tick();
        longint n_err;
        longint n_mout[AN];
        longint n_sp[AN];
        int     n_upd;
        bit     cap;
        longint spu;
        int     ch;
        drive();
        cap   = cei && !m_ceprev && m_armed;
        spu   = SLEW ? m_sp[ai] : m_tgt[ai];
        n_err = m_en[ai] ? sat(spu - p[ai]) : 0;
        n_upd = cap ? (1 << ai) : 0;
        for (int i = 0; i < AN; i++) begin
            n_mout[i] = !m_en[i] ? 0 : ((cap && i == ai) ? mk : m_mout[i]);
            n_sp[i]   = !m_en[i] ? p[i]
                      : ((cap && i == ai) ? step_toward(m_tgt[i], m_sp[i], m_rate[i]) : m_sp[i]);
        end
        @(posedge clk_pid);
        #1;
        m_err = n_err;
        m_upd = n_upd;
        for (int i = 0; i < AN; i++) begin
            m_mout[i] = n_mout[i];
            m_sp[i]   = n_sp[i];
        end
        if (wei) begin
            ch = waddr >> 2;
            case (waddr & 3)
                0: m_tgt[ch]  = sx(longint'(wdat), EW);
                1: m_gain[ch] = int'(wdat & 32'h3FFFF);
                2: begin
                    m_en[ch]   = wdat[0];
                    m_rate[ch] = SLEW ? int'((wdat >> 8) & 32'hFFFF) : 0;
                end
                default: ;
            endcase
        end
        m_ceprev = cei;
        m_armed  = m_armed | !cei;
        wei = 1'b0;
        bus_if.bus_we = 1'b0;
        check("error", sx(longint'(error), EW), m_err);
        for (int i = 0; i < AN; i++)
            check("m_out", sx(longint'(m_out[i*OW +: OW]), OW), m_mout[i]);
        check("upd", longint'(upd), longint'(m_upd));
        check("KP", sx(longint'(KP), CW), sx(longint'(m_gain[ai]), 6));
        check("KI", sx(longint'(KI), CW), sx(longint'(m_gain[ai] >> 6), 6));
        check("KD", sx(longint'(KD), CW), sx(longint'(m_gain[ai] >> 12), 6));
        check("rdata", sx(longint'(bus_if.bus_rdata), 32), readback(waddr));
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        wei = 1'b1; waddr = ch * 4 + r; wdat = d;
        tick();
    endtask

    // Reset mid-cycle with bus and ce activity; nothing may leave reset state.
    task automatic do_reset(input bit keep_ce);
        @(posedge clk_pid);
        #2;
        reset_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (!keep_ce) cei = ~cei;
            wei = 1'b1; waddr = int'($urandom_range(0, 7)); wdat = $urandom;
            mk = sx(longint'($urandom), OW);
            drive();
            @(posedge clk_pid);
            #1;
            check("rst_error", longint'(error), 0);
            check("rst_m_out", longint'(m_out), 0);
            check("rst_upd", longint'(upd), 0);
            check("rst_KP", longint'(KP), 0);
            check("rst_rdata", longint'(bus_if.bus_rdata), 0);
        end
        wei = 1'b0;
        bus_if.bus_we = 1'b0;
        reset_n = 1'b1;
        model_reset();
    endtask

    int cnt;

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < AN; i++) p[i] = 0;
        ai = 0; cei = 1'b0; mk = 0; wei = 1'b0; waddr = 0; wdat = '0;
        drive();
        model_reset();
        do_reset(1'b0);
        cei = 1'b0;

        // Error computation and saturation on channel 0
        ai = 0;
        wr(0, 2, 32'd1);
        wr(0, 0, 32'd1000);
        p[0] = 400;
        tick(); tick();
`ifndef PID_SCHED_SLEW_EN
        check("err_600", sx(longint'(error), EW), 600);
`endif
        p[0] = -8388000;
        wr(0, 0, 32'd8388000);
        tick(); tick();
`ifndef PID_SCHED_SLEW_EN
        check("err_sat_pos", sx(longint'(error), EW), 8388607);
`endif
        p[0] = 8388000;
        wr(0, 0, 32'(-8388000));
        tick(); tick();
`ifndef PID_SCHED_SLEW_EN
        check("err_sat_neg", sx(longint'(error), EW), -8388607);
`endif

        // Capture on channel 1, single pulse while ce stays high
        wr(1, 2, 32'd1);
        ai = 1; mk = -5; cei = 1'b0;
        tick();
        cei = 1'b1;
        tick();
        check("cap_mout1", sx(longint'(m_out[OW +: OW]), OW), -5);
        check("cap_upd", longint'(upd), 2);
        tick();
        check("upd_once", longint'(upd), 0);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 50) ai = 0;   // channel change with ce held high
            tick();
            if (upd != '0) cnt++;
        end
        check("upd_hold", longint'(cnt), 0);
        cei = 1'b0;

        // Disabled channel and bumpless enable
        ai = 0;
        wr(0, 2, 32'd0);
        p[0] = 123;
        tick();
        check("dis_error", sx(longint'(error), EW), 0);
        check("dis_mout0", sx(longint'(m_out[0 +: OW]), OW), 0);
        wr(0, 0, 32'd123);
        wr(0, 2, 32'd1);
        tick();
        check("en_first", sx(longint'(error), EW), 0);

        // Gain write on the capture cycle
        cei = 1'b0;
        tick();
        cei = 1'b1; mk = 77;
        wr(0, 1, 32'h3F246);
        check("wcap_upd", longint'(upd), 1);
        check("wcap_mout0", sx(longint'(m_out[0 +: OW]), OW), 77);
        check("wcap_KP", sx(longint'(KP), CW), 6);
        check("wcap_KI", sx(longint'(KI), CW), 9);
        check("wcap_KD", sx(longint'(KD), CW), -1);

        // Reset with ce held high needs a fresh rising edge afterwards
        do_reset(1'b1);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (upd != '0) cnt++;
        end
        check("no_cap_after_rst", longint'(cnt), 0);
        cei = 1'b0;
        tick();
        cei = 1'b1;
        tick();
        check("fresh_edge", longint'(upd), 1);
        cei = 1'b0;

`ifdef PID_SCHED_SLEW_EN
        // Slew-limited setpoint: 30, 60, 90, 100, 100
        begin
            longint exp_sp[5];
            exp_sp = '{30, 60, 90, 100, 100};
            ai = 0; p[0] = 0;
            wr(0, 2, 32'd0);
            tick();
            wr(0, 0, 32'd100);
            wr(0, 2, (32'd30 << 8) | 32'd1);
            tick();
            for (int k = 0; k < 5; k++) begin
                cei = 1'b1; tick();
                cei = 1'b0; tick();
                check("slew", sx(longint'(error), EW), exp_sp[k]);
            end
        end
`endif

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wei   = 1'b1;
                waddr = int'($urandom_range(0, 7));
                case (waddr & 3)
                    0: wdat = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 1) != 0) ? 8388607 : -8388608)
                                                          : $urandom;
                    2: wdat = ($urandom & 32'h00FFFF00) | 32'($urandom_range(0, 3) != 0);
                    default: wdat = $urandom;
                endcase
            end else begin
                waddr = int'($urandom_range(0, 7));
            end
            for (int i = 0; i < AN; i++)
                if ($urandom_range(0, 4) == 0) p[i] = sx(longint'($urandom), EW);
            if ($urandom_range(0, 4) == 0) ai = int'($urandom_range(0, AN - 1));
            if ($urandom_range(0, 2) == 0) cei = ~cei;
            mk = sx(longint'($urandom), OW);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pid_sched.md
PID_SCHED -- requirements
Module: pid_sched

Interface
REQ-001 SHALL have parameters: aw, default 1, channel address width (an = 2^aw channels); ew, default 24, error/setpoint/position width; ow, default 12, PID output width; cw, default 6, gain width.
REQ-002 SHALL have port clk_pid, input, 1, sole clock.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports bus_we, input, 1, register write strobe; bus_addr, input, aw+2, {channel, reg}; bus_wdata, input, 32, write data; bus_rdata, output, 32, combinational readback.
REQ-005 SHALL have port pos, input, an*ew, packed signed measured positions, channel i at bits [i*ew+ew-1:i*ew].
REQ-006 SHALL have ports a, input, aw, channel the PID datapath is serving; ce, input, 1, datapath output-valid; m_k_out, input, ow, signed datapath output.
REQ-007 SHALL have ports error, output, ew, signed error to datapath; KP, KI, KD, outputs, cw each, signed shift gains for channel a.
REQ-008 SHALL have ports m_out, output, an*ow, packed per-channel captured outputs; upd, output, an, one-cycle per-channel update pulses.

Function
REQ-009 Per-channel registers SHALL be: reg 0 target setpoint (ew bits, signed); reg 1 gains {KD[17:12],KI[11:6],KP[5:0]}; reg 2 control {rate[23:8], en[0]}; reg 3 read-only {captured m_out sign-extended}.
REQ-010 bus_rdata SHALL return the addressed register, zero-extended except reg 0 and reg 3, which are sign-extended; unused bits read 0.
REQ-011 KP/KI/KD SHALL combinationally follow the gains register of channel a.
REQ-012 error SHALL be registered: one clk_pid after a change of a, pos or effective setpoint, error = sat(sp_eff[a] - pos[a]), computed at ew+1 bits.
REQ-013 Saturation SHALL be symmetric: clamp to +(2^(ew-1)-1) and -(2^(ew-1)-1); the value -2^(ew-1) SHALL never be driven.
REQ-014 When en[a]=0, error SHALL be 0, m_out[a] SHALL be 0, and sp_eff[a] SHALL load pos[a] every cycle (bumpless enable).
REQ-015 A ce rising edge (ce=1, previous ce=0) SHALL, on that edge, capture m_k_out into m_out[a] if en[a]=1 and pulse upd[a] for exactly one cycle; ce held high SHALL NOT re-capture.
REQ-016 A channel-address change while ce=1 without a ce low phase SHALL NOT produce a capture.
REQ-017 A bus write and a ce capture on the same cycle SHALL both take effect; a write to reg 1 or reg 0 of channel a SHALL affect error/gains from the next cycle.
REQ-018 Writes to reg 3 SHALL be ignored.

Reset
REQ-019 reset_n low SHALL asynchronously clear all setpoints, sp_eff, gains, control, m_out, upd, error and the ce edge register to 0.
REQ-020 Reset asserted mid-cycle SHALL abort any pending capture; first capture after release needs a fresh ce rising edge.

Configuration
REQ-021 Macro PID_SCHED_SLEW_EN SHALL select setpoint slew limiting.
REQ-022 With PID_SCHED_SLEW_EN defined: on each capture of an enabled channel, sp_eff moves toward target by min(rate, |target - sp_eff|); rate=0 SHALL apply the target immediately; a target written during the capture cycle SHALL be used from the next capture.
REQ-023 Without PID_SCHED_SLEW_EN: sp_eff SHALL equal target whenever en=1, rate bits SHALL read 0 and be ignored.

Verification
REQ-024 Reset with ce toggling and bus writes active -> all outputs 0, upd never pulses while reset_n=0.
REQ-025 ch0 en=1, target=1000, pos0=400, a=0 -> error=600 one cycle later; pos0=-8388000, target=8388000 -> error=8388607.
REQ-026 a=1, ce 0->1, m_k_out=-5 -> m_out ch1=-5, upd=2'b10 for one cycle; ce held 1 for 100 cycles -> no further upd.
REQ-027 en0=0, pos0=123 -> error=0, m_out0=0; set en0=1, target=123 (no slew) -> error=0 first enabled cycle.
REQ-028 SLEW_EN: sp_eff=0, target=100, rate=30, repeated ch0 captures -> sp_eff 30, 60, 90, 100, 100.
REQ-029 Write reg 1 ch0=0x3F246 on a ce rising-edge cycle -> capture occurs and KP=6, KI=9, KD=-1 (0x3F) next cycle.
